// File: rtl/drum_pkg.sv
// Shared constants, S1->S2 payload and truncation helper for the DRUM multiplier.
// Operand width, retained bits and tag width are set here; MANT_W widens under DRUM_EXACT_MODE_EN.
package drum_pkg;

  localparam int WIDTH = 16;
  localparam int K     = 5;
  localparam int TAG_W = 4;
  localparam int SH_W  = $clog2(2 * WIDTH);
  localparam int POS_W = $clog2(WIDTH);

`ifdef DRUM_EXACT_MODE_EN
  localparam int MANT_W = WIDTH;
`else
  localparam int MANT_W = K;
`endif

  typedef struct packed {
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic [POS_W-1:0]  sh_a;
    logic [POS_W-1:0]  sh_b;
    logic [TAG_W-1:0]  tag;
  } s1_payload_t;

  // Keep the K bits below and including the leading one, forcing the LSB to 1 to unbias.
  function automatic logic [K-1:0] drum_trunc(input logic [WIDTH-1:0] x,
                                              input logic [POS_W-1:0] k);
    logic [WIDTH-1:0] sx;
    sx = x >> (k - POS_W'(K - 1));
    if (k >= POS_W'(K)) drum_trunc = sx[K-1:0] | {{(K-1){1'b0}}, 1'b1};
    else                drum_trunc = x[K-1:0];
  endfunction

endpackage

// File: rtl/drum_mul_pipe_if.sv
// Operand/product handshake bundle; in_exact exists only under DRUM_EXACT_MODE_EN.
interface drum_mul_pipe_if;
  import drum_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
`ifdef DRUM_EXACT_MODE_EN
  logic               in_exact;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_r;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag,
`ifdef DRUM_EXACT_MODE_EN
    output in_exact,
`endif
    output out_ready,
    input  in_ready, out_valid, out_r, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag,
`ifdef DRUM_EXACT_MODE_EN
    input  in_exact,
`endif
    input  out_ready,
    output in_ready, out_valid, out_r, out_tag
  );

endinterface

// File: rtl/drum_lod_enc.sv
// Leading-one detector: position of the highest set bit (0 for a zero input) and a nonzero flag.
module drum_lod_enc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         x_i,
  output logic [$clog2(WIDTH)-1:0] pos_o,
  output logic                     nz_o
);

  always_comb begin
    pos_o = '0;
    nz_o  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x_i[i]) begin
        pos_o = ($clog2(WIDTH))'(i);
        nz_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drum_mul_pipe.sv
// 3-stage DRUM approximate multiplier (LOD/truncate, K x K multiply, shift) with valid/ready.
// Build option DRUM_EXACT_MODE_EN adds a per-pair in_exact bypass to a full WIDTH x WIDTH product.
module drum_mul_pipe
  import drum_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  drum_mul_pipe_if.slave bus
);

  logic                  v1_q, v2_q, v3_q;
  logic                  ld1, ld2, ld3;
  logic [POS_W-1:0]      pos_a, pos_b;
  logic                  nz_a, nz_b;
  s1_payload_t           s1_d, s1_q;
  logic [2*MANT_W-1:0]   prod_d, prod_q;
  logic [SH_W-1:0]       sh_d, sh_q;
  logic [TAG_W-1:0]      tag2_q;
  logic [2*WIDTH-1:0]    out_r_d, out_r_q;
  logic [TAG_W-1:0]      out_tag_q;

  // Ready ripples back combinationally from out_ready so a full pipe still streams.
  assign ld3          = !v3_q || bus.out_ready;
  assign ld2          = !v2_q || ld3;
  assign ld1          = !v1_q || ld2;
  assign bus.in_ready = rst_n && ld1;

  drum_lod_enc #(.WIDTH(WIDTH)) u_lod_a (.x_i(bus.in_a), .pos_o(pos_a), .nz_o(nz_a));
  drum_lod_enc #(.WIDTH(WIDTH)) u_lod_b (.x_i(bus.in_b), .pos_o(pos_b), .nz_o(nz_b));

  always_comb begin
    s1_d        = '0;
    s1_d.tag    = bus.in_tag;
    s1_d.mant_a = MANT_W'(drum_trunc(bus.in_a, pos_a));
    s1_d.mant_b = MANT_W'(drum_trunc(bus.in_b, pos_b));
    s1_d.sh_a   = (nz_a && pos_a >= POS_W'(K)) ? pos_a - POS_W'(K - 1) : '0;
    s1_d.sh_b   = (nz_b && pos_b >= POS_W'(K)) ? pos_b - POS_W'(K - 1) : '0;
`ifdef DRUM_EXACT_MODE_EN
    if (bus.in_exact) begin
      s1_d.mant_a = bus.in_a;
      s1_d.mant_b = bus.in_b;
      s1_d.sh_a   = '0;
      s1_d.sh_b   = '0;
    end
`endif
  end

  assign prod_d  = (2*MANT_W)'(s1_q.mant_a) * (2*MANT_W)'(s1_q.mant_b);
  assign sh_d    = SH_W'(s1_q.sh_a) + SH_W'(s1_q.sh_b);
  assign out_r_d = (2*WIDTH)'(prod_q) << sh_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      out_r_q   <= '0;
      out_tag_q <= '0;
    end else begin
      if (ld1) v1_q <= bus.in_valid;
      if (ld2) v2_q <= v1_q;
      if (ld3) begin
        v3_q      <= v2_q;
        out_r_q   <= out_r_d;
        out_tag_q <= tag2_q;
      end
    end
  end

  // Internal stage payloads need no reset: the stage valids gate them.
  always_ff @(posedge clk) begin
    if (ld1) s1_q <= s1_d;
    if (ld2) begin
      prod_q <= prod_d;
      sh_q   <= sh_d;
      tag2_q <= s1_q.tag;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_tag   = out_tag_q;

endmodule
